// File: rtl/l1_dcache_req_queue.sv
// l1_dcache_req_queue: in-order LSU request queue feeding MMU translation and dcache issue
module l1_dcache_req_queue #(
    parameter int DATA_W  = 64,
    parameter int PADDR_W = 56,
    parameter int INDEX_W = 11,
    parameter int VADDR_W = 64,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [1:0]                 req_op_i,
    input  logic [VADDR_W-1:0]         req_vaddr_i,
    input  logic [DATA_W-1:0]          req_wdata_i,
    input  logic [1:0]                 req_size_i,
    output logic                       trn_req_o,
    output logic [VADDR_W-1:0]         trn_vaddr_o,
    input  logic                       trn_valid_i,
    input  logic [PADDR_W-1:0]         trn_paddr_i,
    input  logic                       trn_fault_i,
    output logic                       dc_req_valid_o,
    input  logic                       dc_req_ready_i,
    output logic                       dc_req_we_o,
    output logic                       dc_req_amo_o,
    output logic [INDEX_W-1:0]         dc_req_index_o,
    output logic [PADDR_W-INDEX_W-1:0] dc_req_tag_o,
    output logic [DATA_W-1:0]          dc_req_wdata_o,
    output logic [DATA_W/8-1:0]        dc_req_be_o,
    output logic [1:0]                 dc_req_size_o,
    output logic                       err_valid_o,
    output logic [1:0]                 err_cause_o,
    output logic [VADDR_W-1:0]         err_vaddr_o,
    output logic                       busy_o
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, XLATE, ISSUE, ERR} state_t;

    state_t               state, state_nxt;
    logic [1:0]           op_m  [DEPTH];
    logic [VADDR_W-1:0]   va_m  [DEPTH];
    logic [DATA_W-1:0]    wd_m  [DEPTH];
    logic [1:0]           sz_m  [DEPTH];
    logic                 mis_m [DEPTH];
    logic [PTR_W-1:0]     rd_ptr, wr_ptr, rd_nxt;
    logic [CNT_W-1:0]     count, rem, cnt_nxt;
    logic                 push, pop, mis_in, nh_any, nh_mis, iss;
    logic [PADDR_W-1:0]   paddr_q;
    logic [1:0]           cause_q;
    logic                 busy_q;
    logic [OFF_W-1:0]     off;
    logic [15:0]          be_wide;

    assign req_ready_o = ~rst & (count < CNT_W'(DEPTH));
    assign push        = req_valid_i & req_ready_o;
    assign mis_in      = (|({1'b0, req_vaddr_i[2:0]} & ((4'd1 << req_size_i) - 4'd1)))
                       | (DATA_W == 32 && req_size_i == 2'd3);

    // circular buffer storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                op_m[wr_ptr]  <= req_op_i;
                va_m[wr_ptr]  <= req_vaddr_i;
                wd_m[wr_ptr]  <= req_wdata_i;
                sz_m[wr_ptr]  <= req_size_i;
                mis_m[wr_ptr] <= mis_in;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_nxt;
            count  <= cnt_nxt;
        end
    end

    // next state: IDLE decisions look ahead at whichever entry is head after this edge
    always_comb begin
        pop       = (state == ISSUE && dc_req_ready_i) || state == ERR;
        rem       = count - CNT_W'(pop);
        cnt_nxt   = rem + CNT_W'(push);
        rd_nxt    = rd_ptr + PTR_W'(pop);
        nh_any    = rem != '0 || push;
        nh_mis    = rem != '0 ? mis_m[rd_nxt] : mis_in;
        state_nxt = (state == IDLE || pop) ? (nh_any ? (nh_mis ? ERR : XLATE) : IDLE)
                  : (state == XLATE && trn_valid_i) ? (trn_fault_i ? ERR : ISSUE) : state;
    end

    // state register with translated address, error cause and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            paddr_q <= '0;
            cause_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == XLATE && trn_valid_i)
                paddr_q <= trn_paddr_i;
            if (state_nxt == ERR)
                cause_q <= state == XLATE ? 2'b10 : 2'b01;
            busy_q <= cnt_nxt != '0 || state_nxt != IDLE;
        end
    end

    // outputs decoded from state and head entry, zero outside their phase
    always_comb begin
        iss            = state == ISSUE;
        off            = va_m[rd_ptr][OFF_W-1:0];
        be_wide        = ((16'd1 << (5'd1 << sz_m[rd_ptr])) - 16'd1) << off;
        trn_req_o      = state == XLATE;
        trn_vaddr_o    = trn_req_o ? va_m[rd_ptr] : '0;
        dc_req_valid_o = iss;
        dc_req_we_o    = iss && (op_m[rd_ptr] == 2'b01 || op_m[rd_ptr] == 2'b10);
        dc_req_amo_o   = iss && op_m[rd_ptr] == 2'b10;
        dc_req_index_o = iss ? paddr_q[INDEX_W-1:0] : '0;
        dc_req_tag_o   = iss ? paddr_q[PADDR_W-1:INDEX_W] : '0;
        dc_req_wdata_o = dc_req_we_o ? wd_m[rd_ptr] << {off, 3'b000} : '0;
        dc_req_be_o    = iss ? be_wide[BE_W-1:0] : '0;
        dc_req_size_o  = iss ? sz_m[rd_ptr] : 2'b00;
        err_valid_o    = state == ERR;
        err_cause_o    = err_valid_o ? cause_q : 2'b00;
        err_vaddr_o    = err_valid_o ? va_m[rd_ptr] : '0;
        busy_o         = busy_q;
    end
endmodule

// File: tb/tb_l1_dcache_req_queue.sv
// tb_l1_dcache_req_queue: directed scenarios plus randomized traffic against a queue model
module tb_l1_dcache_req_queue;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid_i = 1'b0, req_ready_o;
    logic [1:0]  req_op_i = '0, req_size_i = '0;
    logic [63:0] req_vaddr_i = '0, req_wdata_i = '0;
    logic        trn_req_o, trn_valid_i = 1'b0, trn_fault_i = 1'b0;
    logic [63:0] trn_vaddr_o;
    logic [55:0] trn_paddr_i = '0;
    logic        dc_req_valid_o, dc_req_ready_i = 1'b0, dc_req_we_o, dc_req_amo_o;
    logic [10:0] dc_req_index_o;
    logic [44:0] dc_req_tag_o;
    logic [63:0] dc_req_wdata_o;
    logic [7:0]  dc_req_be_o;
    logic [1:0]  dc_req_size_o, err_cause_o;
    logic        err_valid_o, busy_o;
    logic [63:0] err_vaddr_o;
    logic [265:0] all_out;

    int cmp = 0, bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] va;
        logic [63:0] wd;
        logic [1:0]  sz;
        logic [55:0] pa;
        bit          flt;
    } ent_t;
    ent_t q[$];

    l1_dcache_req_queue dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_vaddr_i(req_vaddr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
        .trn_req_o(trn_req_o), .trn_vaddr_o(trn_vaddr_o), .trn_valid_i(trn_valid_i),
        .trn_paddr_i(trn_paddr_i), .trn_fault_i(trn_fault_i),
        .dc_req_valid_o(dc_req_valid_o), .dc_req_ready_i(dc_req_ready_i),
        .dc_req_we_o(dc_req_we_o), .dc_req_amo_o(dc_req_amo_o),
        .dc_req_index_o(dc_req_index_o), .dc_req_tag_o(dc_req_tag_o),
        .dc_req_wdata_o(dc_req_wdata_o), .dc_req_be_o(dc_req_be_o),
        .dc_req_size_o(dc_req_size_o), .err_valid_o(err_valid_o),
        .err_cause_o(err_cause_o), .err_vaddr_o(err_vaddr_o), .busy_o(busy_o)
    );

    assign all_out = {trn_req_o, trn_vaddr_o, dc_req_valid_o, dc_req_we_o, dc_req_amo_o,
                      dc_req_index_o, dc_req_tag_o, dc_req_wdata_o, dc_req_be_o, dc_req_size_o,
                      err_valid_o, err_cause_o, err_vaddr_o, busy_o};

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive_req(input logic v, input logic [1:0] op, input logic [63:0] va,
                             input logic [63:0] wd, input logic [1:0] sz);
        req_valid_i = v; req_op_i = op; req_vaddr_i = va; req_wdata_i = wd; req_size_i = sz;
    endtask

    function automatic bit mis_of(ent_t e);
        return (e.va % (64'd1 << e.sz)) != 0;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        cmp++; if ({req_ready_o, all_out} !== '0) begin bad++; $display("FAIL reset_hold: got ready=%b outs=%h required all 0", req_ready_o, all_out); end
        rst = 1'b0; #1;
        cmp++; if (req_ready_o !== 1'b1 || all_out !== '0) begin bad++; $display("FAIL reset_release: got ready=%b outs=%h required ready=1 outs=0", req_ready_o, all_out); end
        tick;
        cmp++; if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL reset_idle: got ready=%b busy=%b required 1/0", req_ready_o, busy_o); end
    endtask

    task automatic test_word_store;
        drive_req(1'b1, 2'b01, 64'h1004, 64'hAABBCCDD, 2'd2);
        tick;
        req_valid_i = 1'b0;
        cmp++; if (trn_req_o !== 1'b1 || trn_vaddr_o !== 64'h1004) begin bad++; $display("FAIL ws_trn: got req=%b va=%h required 1/1004", trn_req_o, trn_vaddr_o); end
        trn_valid_i = 1'b1; trn_paddr_i = 56'h80001004;
        tick;
        trn_valid_i = 1'b0;
        cmp++; if ({dc_req_valid_o, dc_req_we_o, dc_req_amo_o, dc_req_index_o, dc_req_tag_o, dc_req_be_o, dc_req_wdata_o, dc_req_size_o}
                   !== {1'b1, 1'b1, 1'b0, 11'h004, 45'h100002, 8'hF0, 64'hAABBCCDD_00000000, 2'd2}) begin
            bad++; $display("FAIL ws_dc: got v=%b we=%b amo=%b idx=%h tag=%h be=%h wd=%h sz=%0d required 1 1 0 004 100002 f0 aabbccdd00000000 2",
                            dc_req_valid_o, dc_req_we_o, dc_req_amo_o, dc_req_index_o, dc_req_tag_o, dc_req_be_o, dc_req_wdata_o, dc_req_size_o);
        end
        dc_req_ready_i = 1'b1;
        tick;
        dc_req_ready_i = 1'b0;
        cmp++; if (dc_req_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL ws_done: got dcv=%b busy=%b required 0/0", dc_req_valid_o, busy_o); end
    endtask

    task automatic test_fill;
        int issued = 0, cyc = 0;
        bit chk = 0;
        for (int i = 0; i < 5; i++) begin
            cmp++; if (req_ready_o !== (i < 4)) begin bad++; $display("FAIL fill_ready[%0d]: got %b required %b", i, req_ready_o, i < 4); end
            drive_req(1'b1, 2'b00, 64'h100 + 64'(8 * i), 64'($urandom), 2'd3);
            tick;
        end
        req_valid_i = 1'b0;
        while (issued < 4 && cyc < 40) begin
            if (chk) begin
                chk = 0;
                cmp++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL fill_ready_after_pop: got %b required 1", req_ready_o); end
            end
            trn_valid_i = trn_req_o;
            trn_paddr_i = 56'h40000000 | trn_vaddr_o[55:0];
            dc_req_ready_i = dc_req_valid_o;
            if (dc_req_valid_o) begin
                cmp++;
                if (dc_req_index_o !== 11'(64'h100 + 64'(8 * issued)) || dc_req_we_o !== 1'b0 || dc_req_wdata_o !== '0) begin
                    bad++; $display("FAIL fill_order[%0d]: got idx=%h we=%b wd=%h required idx=%h we=0 wd=0", issued, dc_req_index_o, dc_req_we_o, dc_req_wdata_o, 11'(64'h100 + 64'(8 * issued)));
                end
                issued++;
                chk = issued == 1;
            end
            tick;
            cyc++;
        end
        trn_valid_i = 1'b0; dc_req_ready_i = 1'b0;
        cmp++; if (issued != 4) begin bad++; $display("FAIL fill_timeout: got %0d issued required 4", issued); end
        tick;
        cmp++; if (busy_o !== 1'b0) begin bad++; $display("FAIL fill_drain: got busy=%b required 0", busy_o); end
    endtask

    task automatic test_misaligned;
        drive_req(1'b1, 2'b00, 64'h3, 64'h0, 2'd1);
        tick;
        cmp++; if ({err_valid_o, err_cause_o, err_vaddr_o, trn_req_o, dc_req_valid_o} !== {1'b1, 2'b01, 64'h3, 1'b0, 1'b0}) begin
            bad++; $display("FAIL mis_err: got ev=%b cause=%b va=%h trn=%b dcv=%b required 1 01 3 0 0", err_valid_o, err_cause_o, err_vaddr_o, trn_req_o, dc_req_valid_o);
        end
        drive_req(1'b1, 2'b00, 64'h10, 64'h0, 2'd2);
        tick;
        req_valid_i = 1'b0;
        cmp++; if ({err_valid_o, trn_req_o, trn_vaddr_o} !== {1'b0, 1'b1, 64'h10}) begin
            bad++; $display("FAIL mis_next_trn: got ev=%b trn=%b va=%h required 0 1 10", err_valid_o, trn_req_o, trn_vaddr_o);
        end
        trn_valid_i = 1'b1; trn_paddr_i = 56'h10;
        tick;
        trn_valid_i = 1'b0;
        cmp++; if ({dc_req_valid_o, dc_req_index_o, dc_req_we_o} !== {1'b1, 11'h10, 1'b0}) begin
            bad++; $display("FAIL mis_next_dc: got v=%b idx=%h we=%b required 1 010 0", dc_req_valid_o, dc_req_index_o, dc_req_we_o);
        end
        dc_req_ready_i = 1'b1;
        tick;
        dc_req_ready_i = 1'b0;
        cmp++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mis_drain: got busy=%b required 0", busy_o); end
    endtask

    task automatic test_fault;
        drive_req(1'b1, 2'b01, 64'h2000, 64'h1234, 2'd3);
        tick;
        req_valid_i = 1'b0;
        cmp++; if (trn_req_o !== 1'b1) begin bad++; $display("FAIL flt_trn: got %b required 1", trn_req_o); end
        trn_valid_i = 1'b1; trn_fault_i = 1'b1; trn_paddr_i = 56'h2000;
        tick;
        trn_valid_i = 1'b0; trn_fault_i = 1'b0;
        cmp++; if ({err_valid_o, err_cause_o, err_vaddr_o, dc_req_valid_o} !== {1'b1, 2'b10, 64'h2000, 1'b0}) begin
            bad++; $display("FAIL flt_err: got ev=%b cause=%b va=%h dcv=%b required 1 10 2000 0", err_valid_o, err_cause_o, err_vaddr_o, dc_req_valid_o);
        end
        tick;
        cmp++; if ({err_valid_o, dc_req_valid_o, busy_o} !== 3'b000) begin
            bad++; $display("FAIL flt_after: got ev=%b dcv=%b busy=%b required 0 0 0", err_valid_o, dc_req_valid_o, busy_o);
        end
    endtask

    task automatic test_grant_stall;
        drive_req(1'b1, 2'b01, 64'h55, 64'h7E, 2'd0);
        tick;
        trn_valid_i = 1'b1; trn_paddr_i = 56'h12355;
        drive_req(1'b1, 2'b00, 64'h200, 64'h0, 2'd3);
        tick;
        for (int k = 0; k < 6; k++) begin
            trn_valid_i = 1'b0;
            cmp++; if ({dc_req_valid_o, dc_req_we_o, dc_req_amo_o, dc_req_index_o, dc_req_tag_o, dc_req_be_o, dc_req_wdata_o, dc_req_size_o}
                       !== {1'b1, 1'b1, 1'b0, 11'h355, 45'h24, 8'h20, 64'h00007E00_00000000, 2'd0}) begin
                bad++; $display("FAIL stall_dc[%0d]: got v=%b we=%b idx=%h tag=%h be=%h wd=%h required 1 1 355 24 20 00007e0000000000", k, dc_req_valid_o, dc_req_we_o, dc_req_index_o, dc_req_tag_o, dc_req_be_o, dc_req_wdata_o);
            end
            if (k >= 3) begin
                cmp++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL stall_full[%0d]: got ready=%b required 0", k, req_ready_o); end
            end
            drive_req(k < 2, 2'b00, 64'h208 + 64'(8 * k), 64'h0, 2'd3);
            dc_req_ready_i = k == 5;
            tick;
        end
        req_valid_i = 1'b0; dc_req_ready_i = 1'b0;
        cmp++; if ({req_ready_o, dc_req_valid_o, trn_req_o, trn_vaddr_o} !== {1'b1, 1'b0, 1'b1, 64'h200}) begin
            bad++; $display("FAIL stall_pop: got ready=%b dcv=%b trn=%b va=%h required 1 0 1 200", req_ready_o, dc_req_valid_o, trn_req_o, trn_vaddr_o);
        end
        trn_valid_i = 1'b1; trn_paddr_i = 56'h200;
        tick;
        trn_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        cmp++; if (dc_req_valid_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL rmid_pre: got dcv=%b busy=%b required 1/1", dc_req_valid_o, busy_o); end
        rst = 1'b1;
        tick;
        cmp++; if ({req_ready_o, all_out} !== '0) begin bad++; $display("FAIL rmid_zero: got ready=%b outs=%h required all 0", req_ready_o, all_out); end
        rst = 1'b0;
        drive_req(1'b1, 2'b10, 64'h3008, 64'h11, 2'd2);
        tick;
        req_valid_i = 1'b0;
        cmp++; if (trn_req_o !== 1'b1 || trn_vaddr_o !== 64'h3008) begin bad++; $display("FAIL rmid_trn: got req=%b va=%h required 1/3008", trn_req_o, trn_vaddr_o); end
        trn_valid_i = 1'b1; trn_paddr_i = 56'h3008;
        tick;
        trn_valid_i = 1'b0;
        cmp++; if ({dc_req_valid_o, dc_req_amo_o, dc_req_we_o, dc_req_be_o, dc_req_wdata_o} !== {1'b1, 1'b1, 1'b1, 8'h0F, 64'h11}) begin
            bad++; $display("FAIL rmid_dc: got v=%b amo=%b we=%b be=%h wd=%h required 1 1 1 0f 11", dc_req_valid_o, dc_req_amo_o, dc_req_we_o, dc_req_be_o, dc_req_wdata_o);
        end
        dc_req_ready_i = 1'b1;
        tick;
        dc_req_ready_i = 1'b0;
        cmp++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rmid_drain: got busy=%b required 0", busy_o); end
    endtask

    task automatic test_random;
        ent_t e;
        int cyc;
        int nb, off, c;
        logic [63:0] r64, exp_wd;
        logic [7:0]  exp_be;
        q.delete();
        for (cyc = 0; cyc < 800 && (cyc < 400 || q.size() != 0); cyc++) begin
            cmp++; if (req_ready_o !== (q.size() < 4)) begin bad++; $display("FAIL rnd_ready@%0d: got %b required %b", cyc, req_ready_o, q.size() < 4); end
            cmp++; if (busy_o !== (q.size() != 0)) begin bad++; $display("FAIL rnd_busy@%0d: got %b required %b", cyc, busy_o, q.size() != 0); end
            cmp++;
            if (err_valid_o) begin
                if (q.size() == 0) begin bad++; $display("FAIL rnd_err@%0d: got err with empty model required none", cyc); end
                else begin
                    c = q[0].flt ? 2 : mis_of(q[0]) ? 1 : 0;
                    if ({err_cause_o, err_vaddr_o, trn_req_o, dc_req_valid_o} !== {2'(c), q[0].va, 2'b00}) begin
                        bad++; $display("FAIL rnd_err@%0d: got cause=%b va=%h required cause=%0d va=%h", cyc, err_cause_o, err_vaddr_o, c, q[0].va);
                    end
                    void'(q.pop_front());
                end
            end else if (trn_req_o) begin
                if (q.size() == 0 || mis_of(q[0]) || q[0].flt || trn_vaddr_o !== q[0].va || dc_req_valid_o) begin
                    bad++; $display("FAIL rnd_trn@%0d: got va=%h dcv=%b required aligned head va=%h", cyc, trn_vaddr_o, dc_req_valid_o, q.size() ? q[0].va : 64'h0);
                end
            end else if (trn_vaddr_o !== '0) begin
                bad++; $display("FAIL rnd_trn_idle@%0d: got va=%h required 0", cyc, trn_vaddr_o);
            end
            if (dc_req_valid_o) begin
                cmp++;
                if (q.size() == 0) begin bad++; $display("FAIL rnd_dc@%0d: got request with empty model required none", cyc); end
                else begin
                    e = q[0];
                    nb = 1 << e.sz;
                    off = int'(e.va % 8);
                    exp_be = 8'(((1 << nb) - 1) << off);
                    exp_wd = (e.op == 2'b01 || e.op == 2'b10) ? e.wd << (8 * off) : 64'h0;
                    if ({dc_req_we_o, dc_req_amo_o, dc_req_index_o, dc_req_tag_o, dc_req_be_o, dc_req_wdata_o, dc_req_size_o}
                        !== {e.op == 2'b01 || e.op == 2'b10, e.op == 2'b10, e.pa[10:0], e.pa[55:11], exp_be, exp_wd, e.sz}) begin
                        bad++; $display("FAIL rnd_dc@%0d: got we=%b amo=%b idx=%h tag=%h be=%h wd=%h sz=%0d required op=%0d pa=%h be=%h wd=%h sz=%0d",
                                        cyc, dc_req_we_o, dc_req_amo_o, dc_req_index_o, dc_req_tag_o, dc_req_be_o, dc_req_wdata_o, dc_req_size_o, e.op, e.pa, exp_be, exp_wd, e.sz);
                    end
                end
            end
            r64 = {$urandom, $urandom};
            trn_valid_i = trn_req_o && q.size() != 0 && $urandom_range(9) < 6;
            trn_fault_i = $urandom_range(99) < 15;
            trn_paddr_i = r64[55:0];
            if (trn_valid_i) begin q[0].pa = r64[55:0]; q[0].flt = trn_fault_i; end
            dc_req_ready_i = $urandom_range(9) < 6;
            if (dc_req_valid_o && dc_req_ready_i && q.size() != 0) void'(q.pop_front());
            e.op = 2'($urandom); e.sz = 2'($urandom); e.wd = {$urandom, $urandom};
            e.va = {$urandom, $urandom}; e.pa = '0; e.flt = 0;
            if ($urandom_range(3) != 0) e.va = e.va & ~((64'd1 << e.sz) - 64'd1);
            drive_req(cyc < 400 && $urandom_range(1) == 1, e.op, e.va, e.wd, e.sz);
            if (req_valid_i && req_ready_o) q.push_back(e);
            tick;
        end
        req_valid_i = 1'b0; trn_valid_i = 1'b0; trn_fault_i = 1'b0; dc_req_ready_i = 1'b0;
        cmp++; if (q.size() != 0) begin bad++; $display("FAIL rnd_drain_timeout: got %0d pending required 0", q.size()); end
        tick;
    endtask

    initial begin
        test_reset;
        test_word_store;
        test_fill;
        test_misaligned;
        test_fault;
        test_grant_stall;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule

// File: doc/l1_dcache_req_queue.md
# l1_dcache_req_queue

Parametrised load/store/AMO request adapter between the core LSU and the L1 dcache. It buffers up to DEPTH memory requests in order and drives one address translation per request to the MMU. It issues the translated request to the dcache with generated byte enables and lane-aligned write data. Unlike the single-entry adapter it replaces, it adds queueing, valid/ready handshakes, width generics, misalignment detection and translation-fault reporting.

## Interface
Parameters:
- DATA_W, 64, dcache data width in bits; power of 2, 32 or 64.
- PADDR_W, 56, physical address width.
- INDEX_W, 11, dcache index width; the tag is PADDR_W-INDEX_W bits.
- VADDR_W, 64, virtual address width.
- DEPTH, 4, queue entries; power of 2, at least 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  LSU request valid.
- req_ready_o  out  1  queue can accept a request (not full).
- req_op_i  in  2  operation: 00 load, 01 store, 10 AMO, 11 reserved (treated as load).
- req_vaddr_i  in  VADDR_W  virtual address.
- req_wdata_i  in  DATA_W  store data, right-aligned.
- req_size_i  in  2  access size: 0 B, 1 H, 2 W, 3 D.
- trn_req_o  out  1  translation request for the head entry.
- trn_vaddr_o  out  VADDR_W  head virtual address; 0 when trn_req_o=0.
- trn_valid_i  in  1  translation done; paddr and fault valid this cycle.
- trn_paddr_i  in  PADDR_W  translated address.
- trn_fault_i  in  1  translation fault.
- dc_req_valid_o  out  1  dcache request valid.
- dc_req_ready_i  in  1  dcache grant.
- dc_req_we_o  out  1  write (store or AMO).
- dc_req_amo_o  out  1  AMO request.
- dc_req_index_o  out  INDEX_W  paddr[INDEX_W-1:0].
- dc_req_tag_o  out  PADDR_W-INDEX_W  paddr[PADDR_W-1:INDEX_W].
- dc_req_wdata_o  out  DATA_W  write data shifted to the byte lane.
- dc_req_be_o  out  DATA_W/8  byte enables.
- dc_req_size_o  out  2  access size.
- err_valid_o  out  1  one-cycle error pulse for the head request.
- err_cause_o  out  2  01 misaligned, 10 translation fault.
- err_vaddr_o  out  VADDR_W  faulting virtual address.
- busy_o  out  1  queue not empty or FSM not IDLE.

## Operation
- **Enqueue.** A request is enqueued on `req_valid_i & req_ready_o`.
  - Each entry stores op, vaddr, wdata, size and a misaligned flag.
  - The misaligned flag is set when `vaddr[size-1:0]` is not 0.
  - Size 3 with DATA_W=32 is also flagged misaligned.
- **Occupancy.** The queue is a circular buffer with log2(DEPTH)-bit read/write pointers and a (log2(DEPTH)+1)-bit count.
  - `req_ready_o` = count < DEPTH. There is no bypass, so a full queue stays not-ready even if it pops in the same cycle.
  - Pointers wrap from DEPTH-1 to 0.
- **Head FSM.**
  - IDLE -> XLATE when count > 0 and the head entry is aligned.
  - IDLE -> ERR when count > 0 and the head entry is misaligned.
  - XLATE: `trn_req_o`=1.
    - On `trn_valid_i` with `trn_fault_i`=0: register paddr, go to ISSUE.
    - On `trn_valid_i` with `trn_fault_i`=1: go to ERR with cause 10.
  - ISSUE: `dc_req_valid_o`=1 with all `dc_req_*` held stable. On `dc_req_ready_i`, pop the head and go to IDLE.
  - ERR: `err_valid_o`=1 for exactly one cycle with the cause and the head vaddr. Pop the head and go to IDLE. No dcache request is issued.
- **Byte enables and data.** Let off = `vaddr[log2(DATA_W/8)-1:0]`.
  - `dc_req_be_o` = ((1<<(1<<size))-1) << off, truncated to DATA_W/8 bits.
  - `dc_req_wdata_o` = wdata << (8*off) for stores and AMOs; 0 for loads.
- **Simultaneous events.** Enqueue and pop in the same cycle leave count unchanged.
- **Reset.** `rst` at any time discards all entries and any in-flight translation or issue; the FSM returns to IDLE.

## Timing
- **Reset values.** While `rst`=1 and on the first cycle after it, every output is 0, except `req_ready_o`, which is 1 from the first cycle after `rst` falls.
- **Minimum latency.** Request accepted at cycle N into an empty queue:
  - `trn_req_o` = 1 at N+1.
  - With `trn_valid_i` at N+1, `dc_req_valid_o` = 1 at N+2.
  - With `dc_req_ready_i` at N+2, the next head's `trn_req_o` = 1 at N+3.
- **Throughput.** Peak is one request every 2 cycles.
- **Misaligned head.** `err_valid_o` fires the cycle after the entry becomes head in IDLE; `trn_req_o` is never asserted for it.
- **Translation fault.** `err_valid_o` fires 1 cycle after the faulting `trn_valid_i`.
- **Stalls.** `trn_req_o` and `trn_vaddr_o` stay stable until `trn_valid_i`. `dc_req_*` stays stable until `dc_req_ready_i`.
- **Counters.** `busy_o` and the occupancy count are registered; `req_ready_o` is derived combinationally from the count.

## Test plan
- **Word store.** DATA_W=64; store vaddr 0x1004, size 2, wdata 0xAABBCCDD; `trn_valid_i` with paddr 0x80001004 on the first `trn_req_o` cycle.
  - Expect `dc_req_index_o`=0x004, `dc_req_tag_o`=0x100002, `dc_req_be_o`=0xF0, `dc_req_wdata_o`=0xAABBCCDD_00000000, `dc_req_we_o`=1.
  - `dc_req_valid_o` is asserted 2 cycles after acceptance.
- **Fill and back-pressure.** DEPTH=4; 5 back-to-back loads with `trn_valid_i` held 0.
  - `req_ready_o` drops after the 4th accept.
  - After the translations and grants are released, the 4 requests issue in order and `req_ready_o` returns to 1 after the first pop.
- **Misaligned.** Halfword load at vaddr 0x3.
  - Expect `err_valid_o` 1 cycle, `err_cause_o`=01, `err_vaddr_o`=0x3.
  - Expect no `trn_req_o` and no `dc_req_valid_o`; the next queued request proceeds normally.
- **Translation fault.** Store with `trn_fault_i`=1 on `trn_valid_i`.
  - Expect `err_cause_o`=10 one cycle later and no dcache request.
- **Grant stall.** Hold `dc_req_ready_i`=0 for 5 cycles.
  - All `dc_req_*` outputs stay constant and the queue count stays unchanged until the grant.
- **Reset mid-operation.** Assert `rst` while in ISSUE with 3 entries queued.
  - The next cycle all outputs are 0 and `busy_o`=0.
  - After reset a single new request follows the N+1/N+2 timing.
